// File: rtl/hm2_gpio_in_demux_pkg.sv
// Purpose : board constants and shared types for the hostmot2 GPIO input demux.
// Latency : n/a (package only).
// Backpressure: n/a.
package hm2_gpio_in_demux_pkg;

    // DE1-SoC expansion header geometry and hostmot2 port layout
    localparam int GPIOWidth      = 36;
    localparam int NumGPIO        = 2;
    localparam int MuxGPIOIOWidth = 36;
    localparam int IOWidth        = NumGPIO * MuxGPIOIOWidth;
    localparam int IOPorts        = 3;
    localparam int PortWidth      = 24;

    // Input glitch filter sizing
    localparam int FilterBits     = 4;
    localparam int PrescaleWidth  = 16;

    typedef logic [1:0] port_idx_t;

endpackage

// File: rtl/hm2_gpio_in_filter_bit.sv
// Purpose : one input pin: 2-flop synchroniser, optional tick-based glitch filter, output flop.
// Latency : unfiltered 3 edges pin->bit_out; filtered adds filter_len+1 ticks of stable level.
// Backpressure: none, free-running.
//
// Ports: clk/reset_n; pin (async raw pin); filter_en, filter_len, tick (shared filter controls);
//        bit_out (registered synchronised/filtered level).
module hm2_gpio_in_filter_bit
    import hm2_gpio_in_demux_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pin,
    input  logic                  filter_en,
    input  logic [FilterBits-1:0] filter_len,
    input  logic                  tick,
    output logic                  bit_out
);

    logic                  sync1;
    logic                  sync2;
    logic [FilterBits-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            count   <= '0;
            bit_out <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
            if (!filter_en) begin
                // Bypass also covers the 1->0 filter_en transition
                bit_out <= sync2;
                count   <= '0;
            end else if (sync2 == bit_out) begin
                count <= '0;
            end else if (tick) begin
                // >= so that lowering filter_len mid-count qualifies at the next tick
                if (count >= filter_len) begin
                    bit_out <= sync2;
                    count   <= '0;
                end else if (count != '1) begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hm2_gpio_in_demux.sv
// Purpose : map header pins onto hostmot2 IOBits with sync/filter, plus per-port read path.
// Latency : pin->iobits_in 3 edges (unfiltered); rd_en->rd_valid 1 edge.
// Backpressure: none; rd_en accepted every cycle, change flags sticky until read.
//
// Ports: clk/reset_n; gpio_in raw pins; filter_en/filter_len/prescale filter controls;
//        iobits_in mapped inputs; rd_en/rd_port request -> rd_data/rd_valid/rd_err;
//        port_changed sticky per-port change flags.
module hm2_gpio_in_demux
    import hm2_gpio_in_demux_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NumGPIO*GPIOWidth-1:0] gpio_in,
    input  logic [IOWidth-1:0]           filter_en,
    input  logic [FilterBits-1:0]        filter_len,
    input  logic [PrescaleWidth-1:0]     prescale,
    output logic [IOWidth-1:0]           iobits_in,
    input  logic                         rd_en,
    input  port_idx_t                    rd_port,
    output logic [PortWidth-1:0]         rd_data,
    output logic                         rd_valid,
    output logic                         rd_err,
    output logic [IOPorts-1:0]           port_changed
);

    logic [PrescaleWidth-1:0] pre_cnt;
    logic                     tick;
    logic [IOWidth-1:0]       iobits_prev;
    logic [IOPorts-1:0]       slice_diff;
    logic [IOPorts-1:0]       rd_clr;
    logic [PortWidth-1:0]     rd_slice;
    logic                     rd_port_ok;

    // A prescale change is only picked up on reload, so the current period always completes
    assign tick = (pre_cnt == '0);

    // Header g pin k -> IOBits g*MuxGPIOIOWidth+k; header pins beyond MuxGPIOIOWidth are unused
    for (genvar g = 0; g < NumGPIO; g++) begin : g_hdr
        for (genvar k = 0; k < MuxGPIOIOWidth; k++) begin : g_pin
            hm2_gpio_in_filter_bit u_bit (
                .clk        (clk),
                .reset_n    (reset_n),
                .pin        (gpio_in[g*GPIOWidth + k]),
                .filter_en  (filter_en[g*MuxGPIOIOWidth + k]),
                .filter_len (filter_len),
                .tick       (tick),
                .bit_out    (iobits_in[g*MuxGPIOIOWidth + k])
            );
        end
    end

    assign rd_port_ok = (rd_port < port_idx_t'(IOPorts));

    always_comb begin
        slice_diff = '0;
        rd_clr     = '0;
        rd_slice   = '0;
        for (int p = 0; p < IOPorts; p++) begin
            slice_diff[p] = (iobits_in[p*PortWidth +: PortWidth] !=
                             iobits_prev[p*PortWidth +: PortWidth]);
            rd_clr[p]     = rd_en && (rd_port == port_idx_t'(p));
            if (rd_port == port_idx_t'(p)) begin
                rd_slice = iobits_in[p*PortWidth +: PortWidth];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt      <= '0;
            iobits_prev  <= '0;
            port_changed <= '0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            rd_err       <= 1'b0;
        end else begin
            pre_cnt      <= tick ? prescale : pre_cnt - 1'b1;
            iobits_prev  <= iobits_in;
            // A new change in the same cycle as the clearing read keeps the flag set
            port_changed <= slice_diff | (port_changed & ~rd_clr);
            rd_valid     <= rd_en;
            rd_err       <= rd_en && !rd_port_ok;
            if (rd_en) begin
                rd_data <= rd_port_ok ? rd_slice : '0;
            end
        end
    end

endmodule

// File: tb/tb_hm2_gpio_in_demux.sv
// Purpose : directed + randomized bench for hm2_gpio_in_demux against a behavioural model.
// Latency : n/a.
// Backpressure: n/a.
module tb_hm2_gpio_in_demux;

    logic        clk;
    logic        reset_n;
    logic [71:0] gpio_in;
    logic [71:0] filter_en;
    logic [3:0]  filter_len;
    logic [15:0] prescale;
    logic [71:0] iobits_in;
    logic        rd_en;
    logic [1:0]  rd_port;
    logic [23:0] rd_data;
    logic        rd_valid;
    logic        rd_err;
    logic [2:0]  port_changed;

    int n_cmp = 0;
    int n_bad = 0;

    hm2_gpio_in_demux dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .gpio_in      (gpio_in),
        .filter_en    (filter_en),
        .filter_len   (filter_len),
        .prescale     (prescale),
        .iobits_in    (iobits_in),
        .rd_en        (rd_en),
        .rd_port      (rd_port),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_err       (rd_err),
        .port_changed (port_changed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // samp_new / samp_old: mapped pin values seen at the last two clock edges.
    // The output stage at any edge acts on the level sampled two edges earlier.
    logic [71:0] samp_new, samp_old;
    logic [71:0] m_iob, m_iob_d;
    int          m_cnt [72];
    int          m_pc;
    logic [2:0]  m_flags;
    logic [23:0] m_rdata;
    logic        m_rvld, m_rerr;

    task automatic m_reset();
        samp_new = '0;
        samp_old = '0;
        m_iob    = '0;
        m_iob_d  = '0;
        for (int i = 0; i < 72; i++) m_cnt[i] = 0;
        m_pc     = 0;
        m_flags  = '0;
        m_rdata  = '0;
        m_rvld   = 1'b0;
        m_rerr   = 1'b0;
    endtask

    task automatic m_edge();
        logic        tk;
        logic        syn;
        logic [71:0] nxt;
        logic [71:0] mapped;
        tk  = (m_pc == 0);
        nxt = m_iob;
        for (int i = 0; i < 72; i++) begin
            syn = samp_old[i];
            if (!filter_en[i]) begin
                nxt[i]   = syn;
                m_cnt[i] = 0;
            end else if (syn == m_iob[i]) begin
                m_cnt[i] = 0;
            end else if (tk) begin
                if (m_cnt[i] >= int'(filter_len)) begin
                    nxt[i]   = syn;
                    m_cnt[i] = 0;
                end else if (m_cnt[i] < 15) begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end
        end
        m_pc = tk ? int'(prescale) : m_pc - 1;
        for (int p = 0; p < 3; p++) begin
            logic diff;
            logic clr;
            diff = (m_iob[p*24 +: 24] != m_iob_d[p*24 +: 24]);
            clr  = rd_en && (int'(rd_port) == p);
            m_flags[p] = diff | (m_flags[p] & ~clr);
        end
        m_rvld = rd_en;
        m_rerr = rd_en && (rd_port == 2'd3);
        if (rd_en) m_rdata = (rd_port == 2'd3) ? 24'h0 : m_iob[int'(rd_port)*24 +: 24];
        // Header g pin k feeds IOBit g*36+k
        mapped = '0;
        for (int g = 0; g < 2; g++)
            for (int k = 0; k < 36; k++)
                mapped[g*36 + k] = gpio_in[g*36 + k];
        samp_old = samp_new;
        samp_new = mapped;
        m_iob_d  = m_iob;
        m_iob    = nxt;
    endtask

    always @(posedge clk) begin
        if (!reset_n) m_reset();
        else          m_edge();
    end

    always @(negedge reset_n) m_reset();

    // One compare process, mid-cycle, every cycle
    always @(negedge clk) begin
        chk("iobits_in", iobits_in, m_iob);
        chk("port_changed", 72'(port_changed), 72'(m_flags));
        chk("rd_valid", 72'(rd_valid), 72'(m_rvld));
        chk("rd_err", 72'(rd_err), 72'(m_rerr));
        chk("rd_data", 72'(rd_data), 72'(m_rdata));
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic read_port(input logic [1:0] p);
        rd_en   = 1'b1;
        rd_port = p;
        step(1);
        rd_en   = 1'b0;
    endtask

    function automatic logic [71:0] rnd72();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[71:0];
    endfunction

    initial begin
        m_reset();
        reset_n    = 1'b1;
        gpio_in    = '0;
        filter_en  = '0;
        filter_len = '0;
        prescale   = '0;
        rd_en      = 1'b0;
        rd_port    = '0;
        #1 reset_n = 1'b0;
        step(3);
        chk("reset_iobits", iobits_in, 72'h0);
        chk("reset_flags", 72'(port_changed), 72'h0);
        chk("reset_rd_valid", 72'(rd_valid), 72'h0);
        reset_n = 1'b1;
        step(2);

        // All pins high, unfiltered: visible exactly after the 3rd edge
        gpio_in = '1;
        step(2);
        chk("lat_edge2", iobits_in, 72'h0);
        step(1);
        chk("lat_edge3", iobits_in, {72{1'b1}});
        step(2);
        chk("all_flags_set", 72'(port_changed), 72'h7);
        gpio_in = '0;
        step(6);
        read_port(2'd0);
        read_port(2'd1);
        read_port(2'd2);
        step(1);
        chk("flags_cleared", 72'(port_changed), 72'h0);

        // Glitch filter on pin 5, filter_len=3, tick every cycle
        filter_en[5] = 1'b1;
        filter_len   = 4'd3;
        prescale     = 16'd0;
        step(1);
        gpio_in[5] = 1'b1;
        step(2);
        gpio_in[5] = 1'b0;
        step(8);
        chk("glitch_rejected", 72'(iobits_in[5]), 72'h0);
        gpio_in[5] = 1'b1;
        step(5);
        chk("filt5_before", 72'(iobits_in[5]), 72'h0);
        step(1);
        chk("filt5_accept", 72'(iobits_in[5]), 72'h1);

        // Slow ticks: prescale=9, filter_len=1 on IOBit 40 (header 1 pin 4)
        filter_en[40] = 1'b1;
        filter_len    = 4'd1;
        prescale      = 16'd9;
        gpio_in[40]   = 1'b1;
        step(20);
        chk("filt40_before", 72'(iobits_in[40]), 72'h0);
        step(1);
        chk("filt40_accept", 72'(iobits_in[40]), 72'h1);
        chk("others_quiet", iobits_in & ~((72'h1 << 40) | (72'h1 << 5)), 72'h0);

        filter_en  = '0;
        filter_len = '0;
        prescale   = '0;
        gpio_in    = '0;
        step(6);
        read_port(2'd0);
        read_port(2'd1);
        read_port(2'd2);

        // Port 1 read
        gpio_in[47:24] = 24'hA5A5A5;
        step(5);
        read_port(2'd1);
        chk("rd1_valid", 72'(rd_valid), 72'h1);
        chk("rd1_data", 72'(rd_data), 72'hA5A5A5);
        chk("rd1_err", 72'(rd_err), 72'h0);
        chk("rd1_flag_clr", 72'(port_changed[1]), 72'h0);
        read_port(2'd3);
        chk("rd3_valid", 72'(rd_valid), 72'h1);
        chk("rd3_err", 72'(rd_err), 72'h1);
        chk("rd3_data", 72'(rd_data), 72'h0);
        step(1);
        chk("rd_valid_pulse", 72'(rd_valid), 72'h0);

        // Change lands in the same cycle as a clearing read of port 0
        read_port(2'd0);
        gpio_in[0] = 1'b1;
        step(3);
        read_port(2'd0);
        chk("set_wins", 72'(port_changed[0]), 72'h1);
        chk("set_wins_data", 72'(rd_data[0]), 72'h1);

        // Reset mid-count with a read pending
        filter_en[10] = 1'b1;
        filter_len    = 4'd15;
        gpio_in[10]   = 1'b1;
        step(6);
        rd_en   = 1'b1;
        rd_port = 2'd2;
        #1 reset_n = 1'b0;
        step(1);
        rd_en = 1'b0;
        chk("rst_no_valid", 72'(rd_valid), 72'h0);
        chk("rst_iobits", iobits_in, 72'h0);
        chk("rst_flags", 72'(port_changed), 72'h0);
        chk("rst_rd_data", 72'(rd_data), 72'h0);
        reset_n = 1'b1;
        step(17);
        chk("refilter_before", 72'(iobits_in[10]), 72'h0);
        step(1);
        chk("refilter_accept", 72'(iobits_in[10]), 72'h1);

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            gpio_in ^= rnd72() & rnd72() & rnd72() & rnd72();
            if ($urandom_range(0, 199) == 0) filter_en  = rnd72();
            if ($urandom_range(0, 149) == 0) filter_len = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0)  prescale   = 16'($urandom_range(0, 4));
            rd_en   = ($urandom_range(0, 1) == 1);
            rd_port = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 499) == 0) begin
                #1 reset_n = 1'b0;
                step(1);
                reset_n = 1'b1;
            end else begin
                step(1);
            end
        end
        rd_en = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
